ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter for the KSM terminal: the other direction of the PS/2 keyboard receiver.

---
 rtl/ps2_host_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter with a Wishbone slave port.
//
// Sends one command byte at a time to a PS/2 device over the open-drain
// clock/data pair: inhibit the clock, issue the start bit, then shift out
// 8 data bits, odd parity and stop on device-generated falling clock edges,
// and finally sample the device acknowledge bit.
//
// Ports:
//   wb_clk_i, wb_rst_i      system clock, asynchronous active-low reset
//   wb_adr_i[1]             register select (0 = DATA, 1 = CSR)
//   wb_dat_i / wb_dat_o     write / read data (read data valid with ack)
//   wb_cyc_i, wb_stb_i,
//   wb_we_i, wb_sel_i       Wishbone request; writes need wb_sel_i[0]
//   wb_ack_o                bus acknowledge
//   irq / iack              level interrupt request / 1-cycle acknowledge
//   ps2_clk_i, ps2_data_i   PS/2 line levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe 1 = pull the corresponding line low
//   busy_o                  frame in progress
//
// CSR layout: [0] BUSY, [1] DONE, [2] ERR, [6] IE (rw), [7] READY = ~BUSY.
//
// Bus handshake: a request is cyc & stb. wb_ack_o is registered and rises
// one cycle after the request appears, stays high for exactly one cycle and
// is re-armed only after it has dropped. A write takes effect on the cycle
// where ack is high and the request is still present; read data is
// presented on wb_dat_o during that same ack cycle and is zero otherwise.
module ps2_host_tx #(
    parameter int REFCLK      = 50000000,
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000,
    parameter int FILTER      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        irq,
    input  logic        iack,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    output logic        busy_o
);

    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int FLT_W = $clog2(FILTER + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic [2:0]       state;
    logic [7:0]       data_reg;
    logic             done, err, ie, pend;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       bit_cnt;
    logic             data_low;

    logic             clk_meta, clk_sync, dat_meta, dat_sync;
    logic             clk_filt;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall_edge;

    logic             bus_req, wr, wr_data, wr_csr;
    logic             busy, inh_last;
    logic [15:0]      csr_rd;

    // Bits of the bus that are not decoded by this block.
    logic unused_ok;
    assign unused_ok = &{1'b0, wb_adr_i[15:2], wb_adr_i[0], wb_dat_i[15:8],
                         wb_sel_i[1], (REFCLK != 0)};

    // ---------------- line synchronizers and clock glitch filter ----------
    // The filtered clock follows the synchronized clock only after it has
    // held a new level for FILTER consecutive cycles; a falling edge is
    // reported on the cycle the filter accepts a new low level.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else begin
            clk_meta <= ps2_clk_i;
            clk_sync <= clk_meta;
            dat_meta <= ps2_data_i;
            dat_sync <= dat_meta;
            if (clk_sync == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER - 1)) begin
                clk_filt <= clk_sync;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall_edge = clk_filt & ~clk_sync & (flt_cnt == FLT_W'(FILTER - 1));

    // ---------------- bus ----------------
    assign bus_req = wb_cyc_i & wb_stb_i;
    assign wr      = wb_ack_o & bus_req & wb_we_i & wb_sel_i[0];
    assign wr_data = wr & ~wb_adr_i[1];
    assign wr_csr  = wr &  wb_adr_i[1];

    assign busy   = (state != S_IDLE);
    assign csr_rd = {8'h00, ~busy, ie, 3'b000, err, done, busy};

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= bus_req & ~wb_ack_o;
            if (bus_req & ~wb_ack_o & ~wb_we_i) begin
                wb_dat_o <= wb_adr_i[1] ? csr_rd : {8'h00, data_reg};
            end else begin
                wb_dat_o <= '0;
            end
        end
    end

    // ---------------- transmit FSM ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state    <= S_IDLE;
            data_reg <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            ie       <= 1'b0;
            pend     <= 1'b0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            bit_cnt  <= '0;
            data_low <= 1'b0;
        end else begin
            if (wr_csr) begin
                ie <= wb_dat_i[6];
            end
            // Clears come first so a frame end below in the same cycle wins.
            if (iack || wr_data || (wr_csr && !wb_dat_i[6])) begin
                pend <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    data_low <= 1'b0;
                    if (wr_data) begin
                        data_reg <= wb_dat_i[7:0];
                        done     <= 1'b0;
                        err      <= 1'b0;
                        inh_cnt  <= '0;
                        state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
                        state <= S_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    data_low <= 1'b1;
                    to_cnt   <= '0;
                    bit_cnt  <= '0;
                    state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (to_cnt == TO_W'(TIMEOUT_CYC)) begin
                        data_low <= 1'b0;
                        err      <= 1'b1;
                        pend     <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (fall_edge) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            // bit_cnt holds the number of edges already seen.
                            if (bit_cnt < 4'd8) begin
                                data_low <= ~data_reg[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                // Odd parity bit is ~^d; pulling low drives a 0.
                                data_low <= ^data_reg;
                            end else if (bit_cnt == 4'd9) begin
                                data_low <= 1'b0;
                            end else begin
                                // 11th edge: device acknowledge (low = accepted).
                                if (dat_sync) begin
                                    err <= 1'b1;
                                end else begin
                                    done <= 1'b1;
                                end
                                pend  <= 1'b1;
                                state <= S_WAIT_IDLE;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    data_low <= 1'b0;
                    if (clk_sync && dat_sync) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    data_low <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Line drives are decoded straight from state so an asynchronous reset
    // releases both lines immediately.
    assign inh_last    = (state == S_INHIBIT) && (inh_cnt == INH_W'(INHIBIT_CYC - 1));
    assign ps2_clk_oe  = (state == S_INHIBIT);
    assign ps2_data_oe = inh_last || (state == S_REQ) || ((state == S_SHIFT) && data_low);
    assign busy_o      = busy;
    assign irq         = ie & pend;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH  = 200;
    localparam int TO   = 3000;
    localparam int FLT  = 4;
    localparam int HALF = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] adr, dat_i;
    logic [15:0] dat_o;
    logic        cyc, we, stb, ack, irq, iack;
    logic [1:0]  sel;
    logic        clk_oe, data_oe, busy;
    logic        dev_clk, dev_data_low;
    logic        clk_line, data_line;

    assign clk_line  = ~clk_oe & dev_clk;
    assign data_line = ~data_oe & ~dev_data_low;

    ps2_host_tx #(
        .REFCLK(50000000), .INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILTER(FLT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_dat_o(dat_o), .wb_cyc_i(cyc), .wb_we_i(we), .wb_stb_i(stb),
        .wb_sel_i(sel), .wb_ack_o(ack), .irq(irq), .iack(iack),
        .ps2_clk_i(clk_line), .ps2_data_i(data_line),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe), .busy_o(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected frame as the device must see it: {stop, parity, data}.
    logic [9:0] exp_q[$];
    bit m_ie = 0;

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += b[i];
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    function automatic logic [15:0] csr_of(input bit ie, input bit done, input bit err);
        return 16'h0080 + (ie ? 16'h0040 : 16'h0) + (err ? 16'h0004 : 16'h0) + (done ? 16'h0002 : 16'h0);
    endfunction

    // Bus acknowledge model: ack follows one cycle after a request and
    // lasts a single cycle.
    logic exp_ack;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_ack <= 1'b0;
        else        exp_ack <= cyc & stb & ~exp_ack;
    end

    // Per-cycle compare: ack timing, and lines released whenever idle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ack_cycle", ack, exp_ack);
            if (!busy) check("lines_idle", {clk_oe, data_oe}, 2'b00);
            if (clk_oe) check("busy_while_inhibit", busy, 1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
        int n = 0;
        adr = a; dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        do begin @(negedge clk); n++; end while (!ack && n < 10);
        check("wr_ack_latency", n, 1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [15:0] a, output logic [15:0] d);
        int n = 0;
        adr = a; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
        do begin @(negedge clk); n++; end while (!ack && n < 10);
        check("rd_ack_latency", n, 1);
        d = dat_o;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        wb_read(a, d);
        check(name, d, exp);
    endtask

    // Device side: waits for inhibit, measures it, clocks in 10 bits on
    // rising edges and answers the 11th clock with ack (or nack).
    task automatic device_rx(input bit nack, output logic [9:0] rx, output int inh);
        int t = 0;
        rx = '0; inh = 0;
        while (!clk_oe && t < 5000) begin @(negedge clk); t++; end
        check("dev_inhibit_seen", clk_oe, 1'b1);
        if (!clk_oe) return;
        while (clk_oe && inh < 20000) begin inh++; @(negedge clk); end
        check("start_bit", data_line, 1'b0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            rx[i] = data_line;
            dev_clk = 1'b1;
            if (i == 9) dev_data_low = !nack;
            repeat (HALF) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin @(negedge clk); t++; end
        check("busy_drop", busy, 1'b0);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit nack, output logic [9:0] rx);
        int inh;
        logic [9:0] e;
        exp_q.push_back(frame_of(b));
        fork
            wb_write(16'h0000, {8'h00, b}, 2'b01);
            device_rx(nack, rx, inh);
        join
        e = exp_q.pop_front();
        check("frame_bits", rx, e);
        check("inhibit_len", inh, INH);
        wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [9:0] rx;
        logic [7:0] b;
        logic [7:0] pbytes[4];
        logic       ppar[4];
        int t, c, inh;
        pbytes = '{8'h00, 8'hFF, 8'h01, 8'h80};
        ppar   = '{1'b1, 1'b1, 1'b0, 1'b0};
        adr = '0; dat_i = '0; sel = '0; cyc = 0; we = 0; stb = 0; iack = 0;
        dev_clk = 1'b1; dev_data_low = 1'b0;

        repeat (4) @(negedge clk);
        check("rst_outputs", {irq, ack, clk_oe, data_oe, busy}, 5'b0);
        check("rst_dat_o", dat_o, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        read_check("rst_data", 16'h0000, 16'h0000);
        read_check("rst_csr", 16'h0002, 16'h0080);

        wb_write(16'h0002, 16'h0040, 2'b01);
        m_ie = 1;
        read_check("csr_ie", 16'h0002, csr_of(1, 0, 0));

        // Command byte 0xED with literal pins on the model.
        run_frame(8'hED, 0, rx);
        check("ed_literal", rx, 10'h3ED);
        read_check("ed_csr", 16'h0002, 16'h00C2);
        check("ed_irq", irq, 1'b1);
        iack = 1'b1; @(negedge clk); iack = 1'b0; @(negedge clk);
        check("iack_irq", irq, 1'b0);

        // Parity corner bytes.
        for (int i = 0; i < 4; i++) begin
            run_frame(pbytes[i], 0, rx);
            check("parity_literal", rx[8], ppar[i]);
            read_check("parity_csr", 16'h0002, csr_of(m_ie, 1, 0));
        end

        // Random bytes.
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            run_frame(b, 0, rx);
            read_check("rand_csr", 16'h0002, csr_of(m_ie, 1, 0));
            read_check("rand_data", 16'h0000, {8'h00, b});
        end

        // Device refuses the byte.
        b = 8'($urandom_range(0, 255));
        run_frame(b, 1, rx);
        read_check("nack_csr", 16'h0002, csr_of(1, 0, 1));
        check("nack_irq", irq, 1'b1);

        // Write while a frame of 0xED is running is ignored.
        exp_q.push_back(frame_of(8'hED));
        fork
            begin
                wb_write(16'h0000, 16'h00ED, 2'b01);
                repeat (300) @(negedge clk);
                check("busy_mid_frame", busy, 1'b1);
                wb_write(16'h0000, 16'h0055, 2'b01);
            end
            device_rx(0, rx, inh);
        join
        check("busy_write_bits", rx, exp_q.pop_front());
        wait_idle();
        read_check("busy_write_data", 16'h0000, 16'h00ED);

        // Timeout: no device clocks at all.
        wb_write(16'h0000, 16'h0042, 2'b01);
        t = 0;
        while (!clk_oe && t < 100) begin @(negedge clk); t++; end
        while (clk_oe && t < 1000) begin @(negedge clk); t++; end
        check("to_clk_released", clk_oe, 1'b0);
        c = 0;
        while (busy && c < 2 * TO) begin @(negedge clk); c++; end
        check("to_window", (c >= TO) && (c <= TO + 5), 1'b1);
        check("to_lines", {clk_oe, data_oe, busy}, 3'b000);
        read_check("to_csr", 16'h0002, csr_of(1, 0, 1));
        check("to_irq", irq, 1'b1);

        // Reset in the middle of an inhibit phase.
        wb_write(16'h0000, 16'h0012, 2'b01);
        repeat (5) @(negedge clk);
        check("pre_rst_inhibit", clk_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_lines", {clk_oe, data_oe, busy, irq}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        m_ie = 0;
        @(negedge clk);
        read_check("rst_mid_csr", 16'h0002, 16'h0080);
        read_check("rst_mid_data", 16'h0000, 16'h0000);
        b = 8'($urandom_range(0, 255));
        run_frame(b, 0, rx);
        read_check("after_rst_csr", 16'h0002, csr_of(0, 1, 0));
        check("after_rst_irq", irq, 1'b0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
